// File: rtl/cpu_clk_ctrl_if.sv
// Signal bundle between the board top and the CPU clock controller.
// The master drives mode/speed/burst/button/selector; the slave returns the CPU clock, reset and status.
interface cpu_clk_ctrl_if #(
  parameter int CNT_WIDTH   = 25,
  parameter int BURST_WIDTH = 16,
  parameter int SEL_WIDTH   = 1
);
  logic [1:0]             mode;
  logic [CNT_WIDTH-1:0]   speed;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   step_btn;
  logic [SEL_WIDTH-1:0]   sel;

  logic                   clk_cpu;
  logic                   cpu_tick;
  logic                   cpu_rst;
  logic                   busy;
  logic [31:0]            tick_count;
  logic [1:0]             state_dbg;

  modport master (
    output mode, speed, burst_len, step_btn, sel,
    input  clk_cpu, cpu_tick, cpu_rst, busy, tick_count, state_dbg
  );

  modport slave (
    input  mode, speed, burst_len, step_btn, sel,
    output clk_cpu, cpu_tick, cpu_rst, busy, tick_count, state_dbg
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: divided run clock, debounced single step, counted bursts and halt,
// plus a CPU reset stretched over CPU ticks and a running tick counter.
module cpu_clk_ctrl #(
  parameter int CNT_WIDTH       = 25,
  parameter int BURST_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RST_TICKS       = 4,
  parameter int SEL_WIDTH       = 1
) (
  input logic           clk50M,
  input logic           rst,
  cpu_clk_ctrl_if.slave bus
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RST_W = $clog2(RST_TICKS + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_TICKS);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_COUNTED = 2'd2
  } state_t;

  // Button path: 2-FF synchroniser, debounce counter, rising-edge pulse.
  logic            btn_s1, btn_s2, btn_acc, btn_acc_d, step_req;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_acc   <= 1'b0;
      btn_acc_d <= 1'b0;
      step_req  <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= bus.step_btn;
      btn_s2    <= btn_s1;
      if (btn_s2 == btn_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        btn_acc <= btn_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      btn_acc_d <= btn_acc;
      step_req  <= btn_acc & ~btn_acc_d;
    end
  end

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] left_q, left_d;
  logic [1:0]             entry_mode_q, entry_mode_d;
  logic                   clk_q, clk_d;
  logic                   tick_q, tick_d;
  logic                   start_q, start_d;
  logic                   abort;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      left_q       <= '0;
      entry_mode_q <= MODE_RUN;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      entry_mode_q <= entry_mode_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      start_q      <= start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    entry_mode_d = entry_mode_q;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    start_d      = 1'b0;
    abort        = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (bus.mode == MODE_RUN) begin
          state_d      = S_RUN;
          entry_mode_d = MODE_RUN;
          start_d      = 1'b1;
        end else if (bus.mode == MODE_STEP && step_req) begin
          state_d      = S_COUNTED;
          entry_mode_d = MODE_STEP;
          left_d       = BURST_WIDTH'(1);
          start_d      = 1'b1;
        end else if (bus.mode == MODE_BURST && step_req && bus.burst_len != '0) begin
          state_d      = S_COUNTED;
          entry_mode_d = MODE_BURST;
          left_d       = bus.burst_len;
          start_d      = 1'b1;
        end
      end
      default: begin
        abort = (state_q == S_RUN) ? (bus.mode != MODE_RUN) : (bus.mode != entry_mode_q);
        if (abort) left_d = '0;
        if (start_q) begin
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            clk_d  = 1'b1;
            cnt_d  = '0;
            tick_d = 1'b1;
          end
        end else if (!clk_q && abort) begin
          // Low phase can be cut short; a high phase is always completed.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= bus.speed) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
          if (clk_q) begin
            if (abort) begin
              state_d = S_IDLE;
            end else if (state_q == S_COUNTED) begin
              left_d = (left_q > BURST_WIDTH'(1)) ? left_q - BURST_WIDTH'(1) : '0;
              if (left_q <= BURST_WIDTH'(1)) state_d = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  // CPU reset stretch and tick counter; a selector change wins over a same-cycle tick.
  logic [SEL_WIDTH-1:0] sel_q;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                 cpu_rst_q;
  logic [31:0]          tick_count_q;
  logic                 sel_chg;

  assign sel_chg = (bus.sel != sel_q);

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (sel_chg) begin
      rst_cnt_d = RST_LOAD;
    end else if (tick_q && rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RST_W'(1);
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      sel_q        <= bus.sel;
      rst_cnt_q    <= RST_LOAD;
      cpu_rst_q    <= 1'b1;
      tick_count_q <= '0;
    end else begin
      sel_q        <= bus.sel;
      rst_cnt_q    <= rst_cnt_d;
      cpu_rst_q    <= (rst_cnt_d != '0);
      tick_count_q <= sel_chg ? 32'd0 : tick_count_q + 32'(tick_q);
    end
  end

  assign bus.clk_cpu    = clk_q;
  assign bus.cpu_tick   = tick_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.tick_count = tick_count_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: every clk_cpu high pulse is checked against an
// expected-length queue, and the scenario code checks latencies, counts and reset behaviour.
module tb_cpu_clk_ctrl;

  localparam int CNT_WIDTH   = 25;
  localparam int BURST_WIDTH = 16;
  localparam int DEB         = 8;
  localparam int RST_TICKS   = 4;
  localparam int SEL_WIDTH   = 1;

  logic clk50M;
  logic rst;

  cpu_clk_ctrl_if #(.CNT_WIDTH(CNT_WIDTH), .BURST_WIDTH(BURST_WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

  cpu_clk_ctrl #(
    .CNT_WIDTH(CNT_WIDTH), .BURST_WIDTH(BURST_WIDTH), .DEBOUNCE_CYCLES(DEB),
    .RST_TICKS(RST_TICKS), .SEL_WIDTH(SEL_WIDTH)
  ) dut (
    .clk50M(clk50M),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk50M = 1'b0;
  always #5 clk50M = ~clk50M;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: length of every clk_cpu high pulse, plus tick/rise alignment.
  int   hi_len = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk50M) begin
    if (bus.clk_cpu === 1'b1) begin
      hi_len++;
    end else if (hi_len != 0) begin
      if (exp_q.size() == 0) check("hi_unexpected", 32'(hi_len), 32'd0);
      else check("hi_len", 32'(hi_len), exp_q.pop_front());
      hi_len = 0;
    end
    if (bus.cpu_tick === 1'b1 || (bus.clk_cpu === 1'b1 && mon_prev !== 1'b1))
      check("tick_align", 32'(bus.cpu_tick), 32'(bus.clk_cpu === 1'b1 && mon_prev !== 1'b1));
    mon_prev = bus.clk_cpu;
  end

  // Driver tasks
  task automatic cycles(input int k);
    repeat (k) @(posedge clk50M);
    #1;
  endtask

  task automatic push_n(input int k, input logic [31:0] len);
    for (int i = 0; i < k; i++) exp_q.push_back(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  // Counts negedges (including the current cycle's) until clk_cpu equals lvl.
  task automatic wait_clk(input logic lvl, input int budget, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk50M);
      n++;
    end while (bus.clk_cpu !== lvl && n < budget);
    if (bus.clk_cpu !== lvl) check({"timeout_", tag}, 32'(bus.clk_cpu), 32'(lvl));
  endtask

  task automatic watch(input int k, output int busy_n, output int rises);
    logic prev;
    prev   = bus.clk_cpu;
    busy_n = 0;
    rises  = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk50M);
      if (bus.busy) busy_n++;
      if (bus.clk_cpu && !prev) rises++;
      prev = bus.clk_cpu;
    end
  endtask

  int n, n1, n2, ticks, busy_n, rises;
  logic [5:0] chat;
  logic prev_clk;

  initial begin
    rst           = 1'b1;
    bus.mode      = 2'b11;
    bus.speed     = '0;
    bus.burst_len = '0;
    bus.step_btn  = 1'b0;
    bus.sel       = '0;
    cycles(3);
    @(negedge clk50M);
    check("rst_clk_cpu", 32'(bus.clk_cpu), 32'd0);
    check("rst_cpu_tick", 32'(bus.cpu_tick), 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tick_count", bus.tick_count, 32'd0);
    cycles(1);
    rst = 1'b0;

    // RUN, speed=2: 10 full periods of 6, then HALT lets the 11th pulse finish.
    push_n(11, 32'd3);
    bus.speed = CNT_WIDTH'(2);
    bus.mode  = 2'b00;
    wait_clk(1'b1, 20, "run_start", n);
    check("run_start_lat", 32'(n), 32'd3);
    for (int p = 0; p < 10; p++) begin
      wait_clk(1'b0, 20, "run_fall", n1);
      wait_clk(1'b1, 20, "run_rise", n2);
      check("run_period", 32'(n1 + n2), 32'd6);
    end
    check("run_tick_count", bus.tick_count, 32'd10);
    check("run_cpu_rst_off", 32'(bus.cpu_rst), 32'd0);
    cycles(1);
    bus.mode = 2'b11;
    wait_clk(1'b0, 20, "halt_fall", n);
    check("halt_busy", 32'(bus.busy), 32'd0);
    cycles(10);
    check("halt_park", 32'(bus.clk_cpu), 32'd0);

    // RUN, speed=0: period 2; HALT lands in a low phase and stops at once.
    push_n(6, 32'd1);
    bus.speed = '0;
    bus.mode  = 2'b00;
    wait_clk(1'b1, 20, "fast_start", n);
    check("fast_start_lat", 32'(n), 32'd3);
    for (int p = 0; p < 5; p++) begin
      wait_clk(1'b0, 20, "fast_fall", n1);
      wait_clk(1'b1, 20, "fast_rise", n2);
      check("fast_period", 32'(n1 + n2), 32'd2);
    end
    cycles(1);
    bus.mode = 2'b11;
    cycles(3);
    check("fast_halt_busy", 32'(bus.busy), 32'd0);

    // Bounced single step: 5 chatter edges, then a long stable press.
    push_n(1, 32'd4);
    bus.mode  = 2'b01;
    bus.speed = CNT_WIDTH'(3);
    chat      = 6'b110101;
    prev_clk  = bus.clk_cpu;
    busy_n    = 0;
    rises     = 0;
    for (int i = 0; i < 60; i++) begin
      bus.step_btn = (i < 6) ? chat[i] : (i < 26);
      @(negedge clk50M);
      if (bus.busy) busy_n++;
      if (bus.clk_cpu && !prev_clk) rises++;
      prev_clk = bus.clk_cpu;
      cycles(1);
    end
    check("step_rises", 32'(rises), 32'd1);
    // busy covers the start cycle plus the 4-cycle high phase.
    check("step_busy_len", 32'(busy_n), 32'd5);
    check("step_idle", 32'(bus.busy), 32'd0);

    // Burst of 5, speed=1, after a fresh reset so tick_count starts at 0.
    do_reset();
    push_n(5, 32'd2);
    bus.mode      = 2'b10;
    bus.burst_len = BURST_WIDTH'(5);
    bus.speed     = CNT_WIDTH'(1);
    bus.step_btn  = 1'b1;
    wait_clk(1'b1, 40, "burst_start", n);
    check("step_latency", 32'(n), 32'(DEB + 6));
    ticks = bus.cpu_tick ? 1 : 0;
    n = 0;
    do begin
      @(negedge clk50M);
      n++;
      if (bus.cpu_tick) ticks++;
    end while (bus.busy && n < 200);
    check("burst_ticks", 32'(ticks), 32'd5);
    check("burst_tick_count", bus.tick_count, 32'd5);
    check("burst_busy_end", 32'(bus.busy), 32'd0);
    cycles(1);
    bus.step_btn = 1'b0;
    cycles(20);

    // burst_len=0: a press produces no activity.
    bus.burst_len = '0;
    bus.step_btn  = 1'b1;
    watch(30, busy_n, rises);
    check("burst0_busy", 32'(busy_n), 32'd0);
    check("burst0_rises", 32'(rises), 32'd0);
    check("burst0_tick_count", bus.tick_count, 32'd5);
    cycles(1);
    bus.step_btn = 1'b0;
    cycles(20);

    // Mode change mid high phase, speed=9: the pulse keeps its full 10 cycles.
    push_n(1, 32'd10);
    bus.speed = CNT_WIDTH'(9);
    bus.mode  = 2'b00;
    wait_clk(1'b1, 20, "mid_start", n);
    check("mid_start_lat", 32'(n), 32'd3);
    cycles(2);
    bus.mode = 2'b11;
    wait_clk(1'b0, 40, "mid_fall", n);
    check("mid_busy", 32'(bus.busy), 32'd0);
    watch(30, busy_n, rises);
    check("mid_parked", 32'(rises + busy_n), 32'd0);
    push_n(1, 32'd10);
    cycles(1);
    bus.mode = 2'b00;
    wait_clk(1'b1, 20, "rerun_start", n);
    check("rerun_lat", 32'(n), 32'd3);
    cycles(1);
    bus.mode = 2'b11;
    wait_clk(1'b0, 40, "rerun_fall", n);

    // Selector change in RUN, speed=1: cpu_rst returns after 4 further ticks.
    push_n(5, 32'd2);
    bus.speed = CNT_WIDTH'(1);
    cycles(1);
    bus.mode = 2'b00;
    wait_clk(1'b1, 20, "sel_start", n);
    cycles(1);
    bus.sel = ~bus.sel;
    @(negedge clk50M);
    @(negedge clk50M);
    check("sel_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("sel_tick_clr", bus.tick_count, 32'd0);
    ticks = 0;
    n = 0;
    while (bus.cpu_rst && n < 100) begin
      if (bus.cpu_tick) ticks++;
      @(negedge clk50M);
      n++;
    end
    check("sel_rst_ticks", 32'(ticks), 32'd4);
    check("sel_rst_count", bus.tick_count, 32'd4);
    cycles(1);
    bus.mode = 2'b11;
    cycles(2);
    bus.sel = ~bus.sel;
    cycles(50);
    check("halt_cpu_rst_held", 32'(bus.cpu_rst), 32'd1);
    check("halt_tick_clr", bus.tick_count, 32'd0);

    // Reset during the 30th tick of a 100-cycle burst truncates that pulse.
    push_n(29, 32'd2);
    push_n(1, 32'd1);
    bus.mode      = 2'b10;
    bus.burst_len = BURST_WIDTH'(100);
    bus.step_btn  = 1'b1;
    ticks = 0;
    n = 0;
    while (ticks < 30 && n < 400) begin
      @(negedge clk50M);
      n++;
      if (bus.cpu_tick) ticks++;
    end
    check("mid_burst_ticks", 32'(ticks), 32'd30);
    rst = 1'b1;
    @(negedge clk50M);
    check("mb_rst_clk_cpu", 32'(bus.clk_cpu), 32'd0);
    check("mb_rst_busy", 32'(bus.busy), 32'd0);
    check("mb_rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("mb_rst_tick_count", bus.tick_count, 32'd0);
    cycles(1);
    rst          = 1'b0;
    bus.step_btn = 1'b0;
    bus.mode     = 2'b11;
    cycles(5);

    check("sb_remaining", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
